// File: rtl/data_memory_pkg.sv
// Shared definitions for the MEM1/MEM2 data memory: access sizes, defaults
// and the alignment rule.
package data_memory_pkg;

    typedef enum logic [1:0] {
        BYTE     = 2'd0,
        HALFWORD = 2'd1,
        WORD     = 2'd2
    } load_type;

    localparam int MEMORY_SIZE      = 4096;
    localparam int DMEM_MAX_LATENCY = 2;

    // Control fields that travel down the response pipeline with the raw word.
    typedef struct packed {
        logic     valid;
        logic     misaligned;
        logic     out_of_range;
        load_type ltype;
        logic     is_unsigned;
        logic [1:0] offset;
    } ctrl_t;

    function automatic logic is_misaligned(input load_type t, input logic [1:0] offset);
        case (t)
            HALFWORD: return offset[0];
            WORD:     return offset != 2'b00;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// One 8-bit byte lane of the data memory: synchronous write, registered read.
module dmem_lane #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] mem [DEPTH];

    // NOTE: the array and its read register carry no reset so the lane maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        if (re) rdata <= mem[idx];
    end

endmodule

// File: rtl/data_memory.sv
// Byte/halfword/word data memory with lane steering, sign/zero extension and
// 1- or 2-cycle read latency. Define DMEM_BOUNDS_CHECK_EN to add rsp_out_of_range.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int MEM_BYTES    = MEMORY_SIZE,
    parameter int ADDR_W       = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              req_valid,
    input  logic              req_write,
    input  load_type          req_type,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_misaligned
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    output logic              rsp_out_of_range
`endif
);

    localparam int DEPTH = MEM_BYTES / 4;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              accept;
    logic [1:0]        offset;
    logic [ADDR_W-1:0] word_addr;
    logic [IDX_W-1:0]  idx;
    logic              req_oor;
    logic              req_mis;
    logic              do_write;
    logic              do_read;
    logic              unused_addr_bits;

    assign accept    = req_valid && !stall;
    assign offset    = req_addr[1:0];
    assign word_addr = req_addr >> 2;
    assign idx       = word_addr[IDX_W-1:0] & IDX_W'(DEPTH - 1);
    assign unused_addr_bits = ^word_addr;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign req_oor = req_addr >= ADDR_W'(MEM_BYTES);
`else
    assign req_oor = 1'b0;
`endif

    assign req_mis  = is_misaligned(req_type, offset);
    assign do_write = accept && req_write && !req_mis && !req_oor;
    assign do_read  = accept && !req_write;

    logic [3:0]      lane_we;
    logic [3:0][7:0] lane_wd;
    logic [3:0][7:0] lane_rd;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        lane_we = '0;
        lane_wd = '0;
        for (int k = 0; k < 4; k++) begin
            case (req_type)
                BYTE: begin
                    lane_we[k] = do_write && (2'(k) == offset);
                    lane_wd[k] = req_wdata[7:0];
                end
                HALFWORD: begin
                    lane_we[k] = do_write && ((k >> 1) == int'(offset[1]));
                    lane_wd[k] = req_wdata[8*(k%2) +: 8];
                end
                default: begin
                    lane_we[k] = do_write;
                    lane_wd[k] = req_wdata[8*k +: 8];
                end
            endcase
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        dmem_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
            .clk   (clk),
            .we    (lane_we[k]),
            .re    (do_read),
            .idx   (idx),
            .wdata (lane_wd[k]),
            .rdata (lane_rd[k])
        );
    end

    ctrl_t       req_ctrl;
    ctrl_t       s1;
    ctrl_t       fin;
    logic [31:0] fin_raw;

    always_comb begin
        req_ctrl              = '0;
        req_ctrl.valid        = accept && !req_write;
        req_ctrl.misaligned   = accept && req_mis;
        req_ctrl.out_of_range = accept && req_oor;
        req_ctrl.ltype        = req_type;
        req_ctrl.is_unsigned  = req_unsigned;
        req_ctrl.offset       = offset;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    s1 <= '0;
        else if (!stall) s1 <= req_ctrl;
    end

    if (READ_LATENCY >= DMEM_MAX_LATENCY) begin : g_stage2
        ctrl_t       s2;
        logic [31:0] raw2;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s2   <= '0;
                raw2 <= '0;
            end else if (!stall) begin
                s2   <= s1;
                raw2 <= lane_rd;
            end
        end
        assign fin     = s2;
        assign fin_raw = raw2;
    end else begin : g_stage1
        assign fin     = s1;
        assign fin_raw = lane_rd;
    end

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext;

    assign sel_byte = 8'(fin_raw >> {fin.offset, 3'b000});
    assign sel_half = fin.offset[1] ? fin_raw[31:16] : fin_raw[15:0];

    always_comb begin
        case (fin.ltype)
            BYTE:     ext = {{24{sel_byte[7] & ~fin.is_unsigned}}, sel_byte};
            HALFWORD: ext = {{16{sel_half[15] & ~fin.is_unsigned}}, sel_half};
            default:  ext = fin_raw;
        endcase
    end

    // Faulted or absent responses must read as zero, whatever the raw word holds.
    assign rsp_valid      = fin.valid;
    assign rsp_misaligned = fin.misaligned;
    assign rsp_data       = (fin.valid && !fin.misaligned && !fin.out_of_range) ? ext : 32'd0;
`ifdef DMEM_BOUNDS_CHECK_EN
    assign rsp_out_of_range = fin.out_of_range;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a latency-1 and a latency-2 instance share
// the same request stream and are checked against hand-computed values.
module tb_data_memory;
    import data_memory_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    load_type    req_type = WORD;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        v1, m1, v2, m2;
    logic [31:0] d1, d2;
    logic [33:0] r1, r2e, r2;
`ifdef DMEM_BOUNDS_CHECK_EN
    logic        o1, o2, ro1, ro2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory #(.MEM_BYTES(4096), .ADDR_W(32), .READ_LATENCY(1)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .stall(stall), .req_valid(req_valid),
        .req_write(req_write), .req_type(req_type), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(v1), .rsp_data(d1), .rsp_misaligned(m1)
`ifdef DMEM_BOUNDS_CHECK_EN
        , .rsp_out_of_range(o1)
`endif
    );

    data_memory #(.MEM_BYTES(4096), .ADDR_W(32), .READ_LATENCY(2)) dut_l2 (
        .clk(clk), .reset_n(reset_n), .stall(stall), .req_valid(req_valid),
        .req_write(req_write), .req_type(req_type), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(v2), .rsp_data(d2), .rsp_misaligned(m2)
`ifdef DMEM_BOUNDS_CHECK_EN
        , .rsp_out_of_range(o2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input load_type t, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_write    = wr;
        req_type     = t;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    // One request followed by one idle cycle; captures {valid, misaligned, data}
    // of both instances one edge after acceptance and of the latency-2 one a cycle later.
    task automatic access(input logic wr, input load_type t, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        drive(wr, t, uns, a, wd);
        tick();
        idle();
        r1  = {v1, m1, d1};
        r2e = {v2, m2, d2};
`ifdef DMEM_BOUNDS_CHECK_EN
        ro1 = o1;
`endif
        tick();
        r2 = {v2, m2, d2};
`ifdef DMEM_BOUNDS_CHECK_EN
        ro2 = o2;
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({v1, m1, d1, v2, m2, d2} !== 68'd0)
            begin errors++; $display("FAIL reset_state got %h %h exp 0", {v1, m1, d1}, {v2, m2, d2}); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        access(1'b1, WORD, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++;
        if ({r1, r2e, r2} !== 102'd0)
            begin errors++; $display("FAIL store_no_rsp got %h %h %h exp 0", r1, r2e, r2); end
        drive(1'b0, WORD, 1'b0, 32'h10, 32'h0);
        tick();
        idle();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({v1, m1, d1, v2, m2, d2} !== 68'd0)
            begin errors++; $display("FAIL reset_midload got %h %h exp 0", {v1, m1, d1}, {v2, m2, d2}); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) tick();
        checks++;
        if ({v1, m1, d1, v2, m2, d2} !== 68'd0)
            begin errors++; $display("FAIL inflight_dropped got %h %h exp 0", {v1, m1, d1}, {v2, m2, d2}); end
    endtask

    task automatic test_latency();
        access(1'b0, WORD, 1'b0, 32'h10, 32'h0);
        checks++;
        if (r1 !== {2'b10, 32'hDEADBEEF})
            begin errors++; $display("FAIL lat1_load got %h exp %h", r1, {2'b10, 32'hDEADBEEF}); end
        checks++;
        if (r2e !== 34'd0)
            begin errors++; $display("FAIL lat2_early got %h exp 0", r2e); end
        checks++;
        if (r2 !== {2'b10, 32'hDEADBEEF})
            begin errors++; $display("FAIL lat2_load got %h exp %h", r2, {2'b10, 32'hDEADBEEF}); end
        checks++;
        if ({v1, m1, d1} !== 34'd0)
            begin errors++; $display("FAIL lat1_single got %h exp 0", {v1, m1, d1}); end
    endtask

    typedef struct {
        load_type    t;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    task automatic test_extension();
        vec_t vecs [5];
        vecs[0] = '{BYTE,     1'b0, 32'h20, 32'hFFFFFF81};
        vecs[1] = '{BYTE,     1'b1, 32'h20, 32'h00000081};
        vecs[2] = '{HALFWORD, 1'b0, 32'h22, 32'hFFFF80F0};
        vecs[3] = '{HALFWORD, 1'b1, 32'h22, 32'h000080F0};
        vecs[4] = '{BYTE,     1'b0, 32'h21, 32'h0000007F};
        access(1'b1, WORD, 1'b0, 32'h20, 32'h80F07F81);
        for (int i = 0; i < 5; i++) begin
            access(1'b0, vecs[i].t, vecs[i].uns, vecs[i].addr, 32'h0);
            checks++;
            if (r1 !== {2'b10, vecs[i].exp})
                begin errors++; $display("FAIL ext%0d_lat1 got %h exp %h", i, r1, {2'b10, vecs[i].exp}); end
            checks++;
            if (r2 !== {2'b10, vecs[i].exp})
                begin errors++; $display("FAIL ext%0d_lat2 got %h exp %h", i, r2, {2'b10, vecs[i].exp}); end
        end
    endtask

    task automatic test_partial_store();
        access(1'b1, WORD, 1'b0, 32'h30, 32'h11223344);
        access(1'b1, BYTE, 1'b0, 32'h31, 32'hFFFFFFAA);
        access(1'b0, WORD, 1'b0, 32'h30, 32'h0);
        checks++;
        if (r1 !== {2'b10, 32'h1122AA44})
            begin errors++; $display("FAIL sb_merge got %h exp %h", r1, {2'b10, 32'h1122AA44}); end
        // Store then load of the same word on the very next cycle.
        drive(1'b1, HALFWORD, 1'b0, 32'h32, 32'h1234BEEF);
        tick();
        drive(1'b0, WORD, 1'b0, 32'h30, 32'h0);
        tick();
        idle();
        checks++;
        if ({v1, m1, d1} !== {2'b10, 32'hBEEFAA44})
            begin errors++; $display("FAIL sh_raw_lat1 got %h exp %h", {v1, m1, d1}, {2'b10, 32'hBEEFAA44}); end
        tick();
        checks++;
        if ({v2, m2, d2} !== {2'b10, 32'hBEEFAA44})
            begin errors++; $display("FAIL sh_raw_lat2 got %h exp %h", {v2, m2, d2}, {2'b10, 32'hBEEFAA44}); end
        tick();
    endtask

    task automatic test_misaligned();
        access(1'b1, WORD, 1'b0, 32'h40, 32'h0BADF00D);
        access(1'b1, WORD, 1'b0, 32'h41, 32'hFFFFFFFF);
        checks++;
        if (r1 !== {2'b01, 32'h0})
            begin errors++; $display("FAIL sw_mis_lat1 got %h exp %h", r1, {2'b01, 32'h0}); end
        checks++;
        if (r2e !== 34'd0 || r2 !== {2'b01, 32'h0})
            begin errors++; $display("FAIL sw_mis_lat2 got %h/%h exp 0/%h", r2e, r2, {2'b01, 32'h0}); end
        access(1'b0, WORD, 1'b0, 32'h40, 32'h0);
        checks++;
        if (r1 !== {2'b10, 32'h0BADF00D})
            begin errors++; $display("FAIL sw_mis_nowrite got %h exp %h", r1, {2'b10, 32'h0BADF00D}); end
        access(1'b0, HALFWORD, 1'b0, 32'h43, 32'h0);
        checks++;
        if (r1 !== {2'b11, 32'h0} || r2 !== {2'b11, 32'h0})
            begin errors++; $display("FAIL lh_mis got %h/%h exp %h", r1, r2, {2'b11, 32'h0}); end
        access(1'b0, WORD, 1'b0, 32'h42, 32'h0);
        checks++;
        if (r1 !== {2'b11, 32'h0} || r2 !== {2'b11, 32'h0})
            begin errors++; $display("FAIL lw_mis got %h/%h exp %h", r1, r2, {2'b11, 32'h0}); end
    endtask

    task automatic test_back_to_back();
        logic [33:0] exp1 [6];
        logic [33:0] exp2 [6];
        exp1 = '{{2'b10, 32'hDEADBEEF}, {2'b10, 32'h80F07F81}, {2'b10, 32'h80F07F81},
                 {2'b10, 32'h80F07F81}, {2'b10, 32'hBEEFAA44}, 34'd0};
        exp2 = '{34'd0, {2'b10, 32'hDEADBEEF}, {2'b10, 32'hDEADBEEF},
                 {2'b10, 32'hDEADBEEF}, {2'b10, 32'h80F07F81}, {2'b10, 32'hBEEFAA44}};
        idle();
        repeat (2) tick();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(1'b0, WORD, 1'b0, 32'h10, 32'h0);
                1: drive(1'b0, WORD, 1'b0, 32'h20, 32'h0);
                2, 3: begin
                    stall = 1'b1;
                    drive(1'b1, WORD, 1'b0, 32'h30, 32'h99999999);
                end
                4: begin
                    stall = 1'b0;
                    drive(1'b0, WORD, 1'b0, 32'h30, 32'h0);
                end
                default: idle();
            endcase
            tick();
            checks++;
            if ({v1, m1, d1} !== exp1[i])
                begin errors++; $display("FAIL b2b%0d_lat1 got %h exp %h", i, {v1, m1, d1}, exp1[i]); end
            checks++;
            if ({v2, m2, d2} !== exp2[i])
                begin errors++; $display("FAIL b2b%0d_lat2 got %h exp %h", i, {v2, m2, d2}, exp2[i]); end
        end
        idle();
        tick();
    endtask

    task automatic test_wrap();
        access(1'b1, WORD, 1'b0, 32'h004, 32'h0000CAFE);
        access(1'b1, WORD, 1'b0, 32'h1004, 32'h00000005);
`ifdef DMEM_BOUNDS_CHECK_EN
        checks++;
        if ({ro1, ro2, r1[33]} !== 3'b110)
            begin errors++; $display("FAIL oor_store got %b exp 110", {ro1, ro2, r1[33]}); end
        access(1'b0, WORD, 1'b0, 32'h004, 32'h0);
        checks++;
        if (r1 !== {2'b10, 32'h0000CAFE})
            begin errors++; $display("FAIL oor_nowrite got %h exp %h", r1, {2'b10, 32'h0000CAFE}); end
        access(1'b0, WORD, 1'b0, 32'h1004, 32'h0);
        checks++;
        if ({ro1, r1} !== {1'b1, 2'b10, 32'h0} || {ro2, r2} !== {1'b1, 2'b10, 32'h0})
            begin errors++; $display("FAIL oor_load got %h/%h exp %h", {ro1, r1}, {ro2, r2}, {1'b1, 2'b10, 32'h0}); end
`else
        checks++;
        if ({r1, r2} !== 68'd0)
            begin errors++; $display("FAIL wrap_store_rsp got %h/%h exp 0", r1, r2); end
        access(1'b0, WORD, 1'b0, 32'h004, 32'h0);
        checks++;
        if (r1 !== {2'b10, 32'h00000005})
            begin errors++; $display("FAIL wrap_store got %h exp %h", r1, {2'b10, 32'h00000005}); end
        access(1'b0, WORD, 1'b0, 32'h2004, 32'h0);
        checks++;
        if (r2 !== {2'b10, 32'h00000005})
            begin errors++; $display("FAIL wrap_load got %h exp %h", r2, {2'b10, 32'h00000005}); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_extension();
        test_partial_store();
        test_misaligned();
        test_back_to_back();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Synchronous, parametrised data memory for the MEM1/MEM2 stages of the 7-stage core.
- Serves byte, halfword and word loads and stores with RISC-V little-endian lane steering and sign/zero extension.
- Detects misaligned accesses.
- Read latency is configurable as 1 or 2 cycles so the pipeline can spread the access across one or two stages.

Parameters:
- MEM_BYTES, 4096, total capacity in bytes; power of two, at least 4.
- ADDR_W, 32, width of the incoming byte address.
- READ_LATENCY, 2, cycles from accepted load to rsp_valid; legal values 1 or 2.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  freeze: no new request accepted, response pipeline holds
- req_valid  in  1  access request this cycle
- req_write  in  1  1 = store, 0 = load
- req_type  in  load_type  BYTE / HALFWORD / WORD
- req_unsigned  in  1  loads only: zero-extend (LBU/LHU) when 1, sign-extend when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  load result valid
- rsp_data  out  32  extended load result
- rsp_misaligned  out  1  accompanies rsp_valid; also pulses for a rejected store

Behaviour:
- Storage:
  - Four 8-bit lane arrays, MEM_BYTES/4 entries each.
  - Entry index = req_addr[log2(MEM_BYTES)-1:2].
  - Lane k holds byte address offset k.
  - Address bits above the index are ignored (wrap-around).
  - Contents are not reset.
- Accept: a request is accepted when req_valid && !stall.
- Alignment rule:
  - HALFWORD is misaligned if addr[0]=1.
  - WORD is misaligned if addr[1:0]!=0.
  - BYTE is never misaligned.
- Store, aligned:
  - Written at the accepting edge.
  - BYTE writes lane addr[1:0] with wdata[7:0].
  - HALFWORD writes lanes addr[1]*2 and +1 with wdata[15:0].
  - WORD writes all lanes.
- Store, misaligned:
  - No lane is written.
  - rsp_misaligned=1 and rsp_valid=0, emitted with load timing (READ_LATENCY cycles later).
- Store, aligned: produces no response; rsp_valid stays 0.
- Load, aligned:
  - Array read at the accepting edge.
  - Stage-1 register captures raw word, offset, type and unsigned flag.
  - If READ_LATENCY=2, a second register stage follows.
  - Extraction and extension are combinational from the final stage.
  - BYTE: byte at offset, bit 7 replicated unless unsigned.
  - HALFWORD: half at offset[1], bit 15 replicated unless unsigned.
  - WORD: unchanged.
- Load, misaligned: rsp_valid=1, rsp_misaligned=1, rsp_data=0, no array side effects.
- Read-after-write:
  - A load accepted the cycle after a store to the same word returns the new data.
  - Same-cycle load and store are impossible: one request per cycle.
- Stall:
  - All pipeline registers hold.
  - rsp_* outputs hold their values.
  - Request inputs are ignored; no write occurs.
- Reset:
  - Asserting reset_n low at any time, including mid-load, clears all valid/misaligned pipeline bits.
  - rsp_valid=0, rsp_misaligned=0, rsp_data=0 until a new load completes.
  - In-flight loads are dropped.
- Throughput: one request per cycle, fully pipelined.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined:
  - Adds output rsp_out_of_range (1 bit).
  - Any access with req_addr >= MEM_BYTES is treated like a misaligned one: store suppressed, load returns 0.
  - The response carries rsp_out_of_range=1 with rsp_valid/rsp_misaligned timing.
  - rsp_out_of_range resets to 0.
- Undefined:
  - Port absent.
  - Upper address bits silently wrap.

Decomposition:
- Shared definitions package:
  - load_type enum (reused).
  - memory_size default.
  - New constant DMEM_MAX_LATENCY=2.
  - New function for alignment checking: (load_type, offset) -> misaligned.
- Natural sub-module: dmem_lane, one 8-bit synchronous-read RAM with write enable, instantiated four times.
- Steering, extension and pipeline logic live in data_memory.

Test Plan:
- Reset/latency: reset_n low with a load in flight -> rsp_valid=0, rsp_data=0. After release, WORD store 0xDEADBEEF @0x10, then WORD load @0x10 -> rsp_valid exactly READ_LATENCY cycles later with 0xDEADBEEF (check both latencies).
- Extension: word 0x80F07F81 @0x20; LB @0x20 -> 0xFFFFFF81; LBU @0x20 -> 0x00000081; LH @0x22 -> 0xFFFF80F0; LHU @0x22 -> 0x000080F0; LB @0x21 -> 0x0000007F.
- Partial store: word 0x11223344 @0x30; SB 0xAA @0x31 -> word 0x1122AA44; SH 0xBEEF @0x32 -> word 0xBEEFAA44.
- Misalignment: SW @0x41 -> memory unchanged, rsp_misaligned=1 with rsp_valid=0. LH @0x43 -> rsp_valid=1, rsp_misaligned=1, rsp_data=0.
- Back-to-back and stall: loads @0x10, @0x20, @0x30 on consecutive cycles, stall high for 2 cycles mid-stream -> three responses in order, outputs frozen during stall, and a request offered during stall is not performed.
- Wrap/bounds: with MEM_BYTES=4096, SW 0x5 @0x1004 -> lands at 0x004. With DMEM_BOUNDS_CHECK_EN defined: no write, rsp_out_of_range=1.
